// File: rtl/inst_fetch_queue_if.sv
// Handshake and data bundle between the instruction cache, the fetch queue and decode.
//   in_valid/in_rnum/in_pc/in_data : cache response (word 0 in in_data[31:0])
//   in_ready                       : queue has room for a full 8-word response
//   out0_* / out1_*                : head and second entry presented to decode
//   out_accept                     : number of instructions decode takes (0..2)
//   flush                          : discard all contents and any same-cycle write
//   count                          : current occupancy
interface inst_fetch_queue_if #(
  parameter int unsigned PTR_W = 4
) ();
  logic               in_valid;
  logic [3:0]         in_rnum;
  logic [31:0]        in_pc;
  logic [255:0]       in_data;
  logic               in_ready;
  logic               out0_valid;
  logic [31:0]        out0_inst;
  logic [31:0]        out0_pc;
  logic               out1_valid;
  logic [31:0]        out1_inst;
  logic [31:0]        out1_pc;
  logic [1:0]         out_accept;
  logic               flush;
  logic [PTR_W:0]     count;

  // Queue side
  modport slave (
    input  in_valid, in_rnum, in_pc, in_data, out_accept, flush,
    output in_ready, out0_valid, out0_inst, out0_pc,
           out1_valid, out1_inst, out1_pc, count
  );

  // Producer/consumer side
  modport master (
    output in_valid, in_rnum, in_pc, in_data, out_accept, flush,
    input  in_ready, out0_valid, out0_inst, out0_pc,
           out1_valid, out1_inst, out1_pc, count
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Circular instruction buffer between the I-cache and decode.
// Accepts 1..8 instructions per cache response (stored with their PCs) and
// presents up to two in order per cycle. Flush empties it in one cycle.
//   clk   : clock, all state updates on rising edge
//   reset : asynchronous, active-high
//   q     : inst_fetch_queue_if slave (cache response in, two-wide decode out)
module inst_fetch_queue #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PTR_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  inst_fetch_queue_if.slave   q
);

  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned MAX_WR = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t              mem [DEPTH];
  logic [PTR_W-1:0]    head;
  logic [PTR_W-1:0]    tail;
  logic [CNT_W-1:0]    cnt;

  logic                in_ready_c;
  logic                rnum_ok_c;
  logic [3:0]          wr_num_c;
  logic [1:0]          acc_c;
  logic [1:0]          rd_num_c;
  logic [PTR_W-1:0]    head_p1_c;

  // Room for a worst-case response, from registered occupancy only
  assign in_ready_c = (DEPTH - 32'(cnt)) >= 32'(MAX_WR);

  // Write and read amounts for this cycle
  always_comb begin
    rnum_ok_c = (q.in_rnum != 4'd0) && (q.in_rnum <= 4'(MAX_WR));
    wr_num_c  = 4'd0;
    if (q.in_valid && in_ready_c && !q.flush && rnum_ok_c) begin
      wr_num_c = q.in_rnum;
    end
    // Over-accept (including the illegal value 3) is clamped to what is held
    acc_c    = (q.out_accept > 2'd2) ? 2'd2 : q.out_accept;
    rd_num_c = (cnt < CNT_W'(acc_c)) ? 2'(cnt) : acc_c;
  end

  // Entry storage; not reset, validity is tracked by count
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < MAX_WR; i++) begin
      if (i < 32'(wr_num_c)) begin
        mem[tail + PTR_W'(i)] <= '{pc: q.in_pc + 32'(4 * i), inst: q.in_data[32*i +: 32]};
      end
    end
  end

  // Pointer and occupancy registers; flush wins over any same-cycle traffic
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (q.flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      head <= head + PTR_W'(rd_num_c);
      tail <= tail + PTR_W'(wr_num_c);
      cnt  <= cnt + CNT_W'(wr_num_c) - CNT_W'(rd_num_c);
    end
  end

  assign head_p1_c = head + PTR_W'(1);

  // Decode-facing view straight from head/count
  assign q.in_ready   = in_ready_c;
  assign q.out0_valid = cnt >= CNT_W'(1);
  assign q.out0_inst  = mem[head].inst;
  assign q.out0_pc    = mem[head].pc;
  assign q.out1_valid = cnt >= CNT_W'(2);
  assign q.out1_inst  = mem[head_p1_c].inst;
  assign q.out1_pc    = mem[head_p1_c].pc;
  assign q.count      = cnt;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed self-checking bench for inst_fetch_queue.
module tb_inst_fetch_queue;

  logic clk = 1'b0;
  logic reset;
  bit   inv_en = 1'b0;

  always #5 clk = ~clk;

  inst_fetch_queue_if #(.PTR_W(4)) bus ();

  inst_fetch_queue #(.DEPTH(16), .PTR_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.in_valid   = 1'b0;
    bus.in_rnum    = 4'd0;
    bus.out_accept = 2'd0;
    bus.flush      = 1'b0;
  endtask

  task automatic load(input logic [31:0] pc, input logic [3:0] n,
                      input logic [31:0] base, input logic [31:0] inc);
    bus.in_valid = 1'b1;
    bus.in_rnum  = n;
    bus.in_pc    = pc;
    for (int i = 0; i < 8; i++) bus.in_data[32*i +: 32] = base + inc * 32'(i);
  endtask

  task automatic check_o0(input string tag, input logic [31:0] inst, input logic [31:0] pc);
    check({tag, ".o0v"},  64'(bus.out0_valid), 64'd1);
    check({tag, ".o0i"},  64'(bus.out0_inst), 64'(inst));
    check({tag, ".o0pc"}, 64'(bus.out0_pc), 64'(pc));
  endtask

  task automatic check_o1(input string tag, input logic [31:0] inst, input logic [31:0] pc);
    check({tag, ".o1v"},  64'(bus.out1_valid), 64'd1);
    check({tag, ".o1i"},  64'(bus.out1_inst), 64'(inst));
    check({tag, ".o1pc"}, 64'(bus.out1_pc), 64'(pc));
  endtask

  // tail must always equal head + count modulo 16
  always @(negedge clk) begin
    logic [3:0] sum;
    if (inv_en) begin
      sum = dut.head + dut.cnt[3:0];
      check("invariant", 64'(dut.tail), 64'(sum));
    end
  end

  logic [31:0] exp_inst [11];
  logic [31:0] exp_pc   [11];

  initial begin
    // Expected drain order for the wrap-straddle scenario
    for (int i = 0; i < 5; i++) begin
      exp_inst[i] = 32'hE0 + 32'(i);
      exp_pc[i]   = 32'h5000 + 32'(4 * i);
    end
    exp_inst[5] = 32'hF0; exp_pc[5]  = 32'hFFFF_FFF4;
    exp_inst[6] = 32'hF1; exp_pc[6]  = 32'hFFFF_FFF8;
    exp_inst[7] = 32'hF2; exp_pc[7]  = 32'hFFFF_FFFC;
    exp_inst[8] = 32'hF3; exp_pc[8]  = 32'h0000_0000;
    exp_inst[9] = 32'hF4; exp_pc[9]  = 32'h0000_0004;
    exp_inst[10] = 32'hF5; exp_pc[10] = 32'h0000_0008;

    reset = 1'b1;
    idle_in();
    bus.in_pc   = '0;
    bus.in_data = '0;
    step();
    step();
    check("rst.in_ready", 64'(bus.in_ready), 64'd1);
    check("rst.o0v", 64'(bus.out0_valid), 64'd0);
    check("rst.o1v", 64'(bus.out1_valid), 64'd0);
    check("rst.count", 64'(bus.count), 64'd0);
    reset  = 1'b0;
    inv_en = 1'b1;
    step();
    check("idle.in_ready", 64'(bus.in_ready), 64'd1);
    check("idle.o0v", 64'(bus.out0_valid), 64'd0);
    check("idle.count", 64'(bus.count), 64'd0);

    // First 8-word response
    load(32'hBFC0_0000, 4'd8, 32'h11, 32'h11);
    step();
    idle_in();
    check("w1.count", 64'(bus.count), 64'd8);
    check("w1.in_ready", 64'(bus.in_ready), 64'd1);
    check_o0("w1", 32'h11, 32'hBFC0_0000);
    check_o1("w1", 32'h22, 32'hBFC0_0004);

    // Second response fills the queue
    load(32'h2000, 4'd8, 32'hA0, 32'h1);
    step();
    idle_in();
    check("w2.count", 64'(bus.count), 64'd16);
    check("w2.in_ready", 64'(bus.in_ready), 64'd0);

    // Write while not ready is dropped
    load(32'h9000, 4'd8, 32'h99, 32'h1);
    step();
    idle_in();
    check("perr.count", 64'(bus.count), 64'd16);
    check_o0("perr", 32'h11, 32'hBFC0_0000);

    // Drain 8
    bus.out_accept = 2'd2;
    for (int i = 0; i < 4; i++) step();
    idle_in();
    check("drain.count", 64'(bus.count), 64'd8);
    check("drain.in_ready", 64'(bus.in_ready), 64'd1);
    check_o0("drain", 32'hA0, 32'h2000);
    check_o1("drain", 32'hA1, 32'h2004);

    // Simultaneous write of 3 and read of 2; tail sits at 0 after wrapping
    load(32'h1000, 4'd3, 32'hC0, 32'h1);
    bus.out_accept = 2'd2;
    step();
    idle_in();
    check("wr_rd.count", 64'(bus.count), 64'd9);
    check_o0("wr_rd", 32'hA2, 32'h2008);
    bus.out_accept = 2'd2;
    for (int i = 0; i < 3; i++) step();
    idle_in();
    check("wrapped.count", 64'(bus.count), 64'd3);
    check_o0("wrapped", 32'hC0, 32'h1000);
    check_o1("wrapped", 32'hC1, 32'h1004);
    bus.out_accept = 2'd2;
    step();
    idle_in();
    check("last.count", 64'(bus.count), 64'd1);
    check_o0("last", 32'hC2, 32'h1008);
    check("last.o1v", 64'(bus.out1_valid), 64'd0);

    // Over-accept with one entry: consumes one only
    bus.out_accept = 2'd2;
    step();
    idle_in();
    check("under.count", 64'(bus.count), 64'd0);
    check("under.head", 64'(dut.head), 64'd3);
    check("under.o0v", 64'(bus.out0_valid), 64'd0);

    // Illegal rnum of 0 writes nothing
    load(32'h7000, 4'd0, 32'h70, 32'h1);
    step();
    idle_in();
    check("rnum0.count", 64'(bus.count), 64'd0);

    // Flush with same-cycle write and accept
    load(32'h3000, 4'd5, 32'h30, 32'h1);
    step();
    idle_in();
    check("pre_fl.count", 64'(bus.count), 64'd5);
    load(32'h3100, 4'd4, 32'h40, 32'h1);
    bus.out_accept = 2'd2;
    bus.flush      = 1'b1;
    #1;
    check_o0("fl_cycle", 32'h30, 32'h3000);
    step();
    idle_in();
    check("fl.count", 64'(bus.count), 64'd0);
    check("fl.head", 64'(dut.head), 64'd0);
    check("fl.tail", 64'(dut.tail), 64'd0);
    check("fl.o0v", 64'(bus.out0_valid), 64'd0);
    check("fl.o1v", 64'(bus.out1_valid), 64'd0);
    step();
    check("fl.after", 64'(bus.count), 64'd0);

    // Build a write that straddles index 15 -> 0 with PCs wrapping 2^32
    load(32'h4000, 4'd8, 32'hD0, 32'h1);
    step();
    load(32'h5000, 4'd5, 32'hE0, 32'h1);
    step();
    idle_in();
    check("st.count13", 64'(bus.count), 64'd13);
    check("st.in_ready", 64'(bus.in_ready), 64'd0);
    bus.out_accept = 2'd2;
    for (int i = 0; i < 4; i++) step();
    idle_in();
    check("st.count5", 64'(bus.count), 64'd5);
    load(32'hFFFF_FFF4, 4'd6, 32'hF0, 32'h1);
    step();
    idle_in();
    check("st.count11", 64'(bus.count), 64'd11);
    check_o0("st0", exp_inst[0], exp_pc[0]);
    check_o1("st0", exp_inst[1], exp_pc[1]);
    for (int k = 0; k < 5; k++) begin
      bus.out_accept = 2'd2;
      step();
      idle_in();
      check($sformatf("st%0d.count", k + 1), 64'(bus.count), 64'(9 - 2 * k));
      check_o0($sformatf("st%0d", k + 1), exp_inst[2*k+2], exp_pc[2*k+2]);
      if (2 * k + 3 < 11) check_o1($sformatf("st%0d", k + 1), exp_inst[2*k+3], exp_pc[2*k+3]);
      else check($sformatf("st%0d.o1v", k + 1), 64'(bus.out1_valid), 64'd0);
    end

    // Asynchronous reset between edges during a write
    load(32'h6000, 4'd4, 32'h60, 32'h1);
    inv_en = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    check("arst.count", 64'(bus.count), 64'd0);
    check("arst.o0v", 64'(bus.out0_valid), 64'd0);
    check("arst.in_ready", 64'(bus.in_ready), 64'd1);
    step();
    idle_in();
    check("arst.hold", 64'(bus.count), 64'd0);
    reset = 1'b0;
    inv_en = 1'b1;
    step();
    check("arst.rel", 64'(bus.count), 64'd0);
    check("arst.rel.head", 64'(dut.head), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Instruction buffer directly downstream of the instruction cache.
- Each cache response delivers a 256-bit line fragment holding 1..8 valid 32-bit instructions (word 0 in bits [31:0]), plus the PC of word 0.
- The block stores each instruction with its PC in a circular FIFO and presents up to two instructions per cycle, in order, to decode.
- Pipeline flushes (branch mispredict, exception) empty it in one cycle.

Parameters:
- DEPTH, 16, number of instruction entries; power of two, minimum 16.
- PTR_W, 4, log2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  cache response valid (the cache's data_ok).
- in_rnum  in  4  number of valid instructions in in_data, legal 1..8.
- in_pc  in  32  PC of the instruction in in_data[31:0].
- in_data  in  256  instruction words; word i is in_data[32i+31:32i].
- in_ready  out  1  queue can accept a full 8-word response this cycle.
- out0_valid  out  1  head entry valid.
- out0_inst  out  32  head instruction.
- out0_pc  out  32  head PC.
- out1_valid  out  1  second entry valid.
- out1_inst  out  32  second instruction.
- out1_pc  out  32  second PC.
- out_accept  in  2  number of instructions decode consumes this cycle (0..2).
- flush  in  1  discard all contents and any same-cycle write.
- count  out  PTR_W+1  current occupancy, for debug and perf counters.

Behaviour:
- State:
  - head pointer and tail pointer, each PTR_W bits, wrapping modulo DEPTH.
  - count, PTR_W+1 bits.
  - Entry array of {pc[31:0], inst[31:0]}.
- Reset (async, active-high): head=0, tail=0, count=0. Entry array is not reset.
  - Output values during reset: in_ready=1, out0_valid=0, out1_valid=0.
- in_ready = (DEPTH - count) >= 8. Purely a function of registered count; never depends on out_accept or flush in the same cycle.
- Write:
  - wr_num = in_rnum when in_valid && in_ready && !flush && 1<=in_rnum<=8, else 0.
  - For each i < wr_num: entry[(tail+i) mod DEPTH] <= {in_pc + 4*i, word i}.
  - PC arithmetic is 32-bit and wraps modulo 2^32.
  - tail <= tail + wr_num, modulo DEPTH.
  - in_valid while in_ready=0 is a producer protocol error. Data is dropped; no state changes.
- Read:
  - rd_num = min(out_accept, count); over-accept is clamped, never underflows.
  - head <= head + rd_num, modulo DEPTH.
- Outputs are combinational from head and count:
  - out0 shows entry[head]; out0_valid = count >= 1.
  - out1 shows entry[head+1 mod DEPTH]; out1_valid = count >= 2.
  - When a valid is 0, the corresponding inst/pc are don't-care.
  - out_accept=2 with out1_valid=0 is treated as 1.
- Latency:
  - Data written in cycle N is visible on the outputs in cycle N+1. No write-to-read bypass.
- Simultaneous write and read in one cycle: count <= count + wr_num - rd_num. Reads always see pre-write contents.
- Flush has priority over everything:
  - Next cycle head=0, tail=0, count=0.
  - Same-cycle write is dropped; same-cycle out_accept is ignored.
  - Outputs are still driven from pre-flush state during the flush cycle.
- Wrap-around: a multi-word write that straddles index DEPTH-1 -> 0 splits correctly, and PCs stay contiguous across the wrap.
- Full: count=DEPTH is reachable only via reads lagging writes. count never exceeds DEPTH, because in_ready guarantees 8 free entries before any write.
- No state machine beyond the pointer/count registers. Invariant: tail == (head + count) mod DEPTH. The bench asserts this every cycle.

Test Plan:
- Reset then idle -> in_ready=1, out0_valid=out1_valid=0, count=0.
- Write in_pc=0xBFC00000, rnum=8, words 0x11..0x88, out_accept=0 -> next cycle count=8, out0={0x11, 0xBFC00000}, out1={0x22, 0xBFC00004}. Second write rnum=8 -> count=16, in_ready=0.
- Fill to 16, then out_accept=2 for 4 cycles -> count=8, in_ready=1. Write rnum=3 at pc 0x1000 while out_accept=2 in the same cycle -> count=9. Entries wrap past index 15 with PCs 0x1000, 0x1004, 0x1008.
- count=1, out_accept=2 -> only 1 consumed, count=0, no underflow. Invariant holds.
- count=5, in_valid with rnum=4, out_accept=2, flush=1 -> next cycle count=0, head=tail=0, outputs invalid.
- Assert reset asynchronously mid-write (between clock edges) -> count=0 and out0_valid=0 immediately, before the next clock edge.
